// File: rtl/nv_fifo_rws_64x32_ctl_pkg.sv
// Shared constants for the 64x32 rws FIFO controller and its RAM.
// DEPTH/AW/DW are fixed by the RAM macro; PW is the pointer and occupancy
// width (one extra bit that acts as the wrap flag).
package nv_fifo_rws_64x32_ctl_pkg;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int PW    = AW + 1;

    // Advance a wrap-bit pointer: the low AW bits roll 63->0 and the carry
    // toggles the wrap bit, so full and empty stay distinguishable.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return p + PW'(1);
    endfunction

endpackage

// File: rtl/nv_ram_rws_64x32.sv
// nv_ram_rws_64x32: 64x32 two-port RAM with a registered read address.
// The read address is captured on re; dout is the entry at that captured
// address, so dout is stable for as long as re stays low and the entry is
// not rewritten. Contents are never reset.
module nv_ram_rws_64x32
    import nv_fifo_rws_64x32_ctl_pkg::*;
(
    input  logic          clk,
    input  logic [5:0]    ra,
    input  logic          re,
    input  logic [5:0]    wa,
    input  logic          we,
    input  logic [31:0]   di,
    input  logic [31:0]   pwrbus_ram_pd,
    output logic [31:0]   dout
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_ra;
    logic          w_pwrbus_unused;

    // Power-down bus only matters to the physical macro; fold it so it is consumed.
    assign w_pwrbus_unused = ^pwrbus_ram_pd;

    // Write port: one word per cycle when we is high.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[wa] <= di;
        end
    end

    // Read address latch: updates only when a read is issued.
    always_ff @(posedge clk) begin
        if (re) begin
            r_ra <= ra;
        end
    end

    assign dout = r_mem[r_ra];

endmodule

// File: rtl/nv_fifo_rws_64x32_ctl.sv
// nv_fifo_rws_64x32_ctl: 64-entry valid/ready FIFO around nv_ram_rws_64x32.
// The RAM output is presented directly as rd_pd; a stalled read simply does
// not issue another read, so the latched RAM address (and rd_pd) holds.
// Build macro NV_FIFO_CTL_WMARK_EN adds input wmark and output almost_full.
module nv_fifo_rws_64x32_ctl
    import nv_fifo_rws_64x32_ctl_pkg::*;
(
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [31:0]   wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [31:0]   rd_pd,
    input  logic [31:0]   pwrbus_ram_pd,
`ifdef NV_FIFO_CTL_WMARK_EN
    input  logic [6:0]    wmark,
    output logic          almost_full,
`endif
    output logic          fifo_idle
);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_iss_ptr;
    logic [PW-1:0] r_occ;
    logic          r_rd_pvld;

    logic          w_wr_accept;
    logic          w_re;
    logic          w_pop;
    logic [PW-1:0] w_unread;

    // Ready depends only on registered occupancy: a pop at full cannot
    // open a slot for a same-cycle write.
    assign wr_prdy     = nvdla_core_rstn && (r_occ != PW'(DEPTH));
    assign w_wr_accept = wr_pvld && wr_prdy;

    // Words written but not yet issued to the RAM read port.
    assign w_unread = r_wr_ptr - r_rd_iss_ptr;

    // Issue a read whenever there is something unread and the output slot
    // is free or being vacated this cycle.
    assign w_re  = nvdla_core_rstn && (w_unread != '0) && (!r_rd_pvld || rd_prdy);
    assign w_pop = r_rd_pvld && rd_prdy;

    // Pointer, occupancy and output-valid state; reset discards all contents.
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            r_wr_ptr     <= '0;
            r_rd_iss_ptr <= '0;
            r_occ        <= '0;
            r_rd_pvld    <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_re) begin
                r_rd_iss_ptr <= ptr_inc(r_rd_iss_ptr);
            end
            if (w_re) begin
                r_rd_pvld <= 1'b1;
            end else if (rd_prdy) begin
                r_rd_pvld <= 1'b0;
            end
            // The presented word stays counted until popped, so its RAM
            // slot cannot be overwritten while it is on rd_pd.
            case ({w_wr_accept, w_pop})
                2'b10:   r_occ <= r_occ + PW'(1);
                2'b01:   r_occ <= r_occ - PW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign rd_pvld   = r_rd_pvld;
    assign fifo_idle = (r_occ == '0);

`ifdef NV_FIFO_CTL_WMARK_EN
    assign almost_full = (r_occ >= wmark);
`endif

    nv_ram_rws_64x32 u_ram (
        .clk           (nvdla_core_clk),
        .ra            (r_rd_iss_ptr[AW-1:0]),
        .re            (w_re),
        .wa            (r_wr_ptr[AW-1:0]),
        .we            (w_wr_accept),
        .di            (wr_pd),
        .pwrbus_ram_pd (pwrbus_ram_pd),
        .dout          (rd_pd)
    );

endmodule
